// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state type and constants for the UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PRESCALE_8     = 8;
  localparam int unsigned PRESCALE_16    = 16;
  localparam int unsigned PRESCALE_32    = 32;

  // Anything other than a supported ratio falls back to 8x oversampling.
  function automatic logic [31:0] legal_prescale(input logic [31:0] p);
    if (p == 32'(PRESCALE_16) || p == 32'(PRESCALE_32)) return p;
    return 32'(PRESCALE_8);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 3-point majority vote around the centre of each bit time.
module uart_rx_sampler #(
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      sampled_bit
);

  logic [PRESCALE_WIDTH-1:0] w_mid;
  logic [2:0]                r_samp;

  assign w_mid = Prescale >> 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_samp <= '1;
    end else begin
      if (edge_cnt == w_mid - PRESCALE_WIDTH'(1)) r_samp[0] <= RX_IN;
      if (edge_cnt == w_mid)                      r_samp[1] <= RX_IN;
      if (edge_cnt == w_mid + PRESCALE_WIDTH'(1)) r_samp[2] <= RX_IN;
    end
  end

  assign sampled_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) |
                       (r_samp[1] & r_samp[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receiver with start-glitch rejection and stop checking.
// Define UART_RX_PARITY_EN to build the optional PARITY state and parity checker.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      stop_error
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e                 r_state, w_state_nxt;
  logic [PRESCALE_WIDTH-1:0] r_edge_cnt, w_edge_cnt_nxt;
  logic [PRESCALE_WIDTH-1:0] r_prescale, w_prescale_nxt, w_prescale_in;
  logic [BitCntW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0]     r_shift, w_shift_nxt;
  logic [DATA_WIDTH-1:0]     r_p_data, w_p_data_nxt;
  logic                      r_data_valid, w_data_valid_nxt;
  logic                      r_stop_error, w_stop_error_nxt;
  logic                      w_sampled, w_bit_end, w_par_err;

`ifdef UART_RX_PARITY_EN
  logic r_par_en, w_par_en_nxt, r_par_typ, w_par_typ_nxt;
  logic r_par_err, w_par_err_nxt, r_parity_error, w_parity_error_nxt;
  assign w_par_err = r_par_err;
`else
  logic w_unused_par;
  assign w_unused_par = PAR_EN ^ PAR_TYP;
  assign w_par_err    = 1'b0;
`endif

  assign w_prescale_in = PRESCALE_WIDTH'(legal_prescale(32'(Prescale)));
  assign w_bit_end     = (r_edge_cnt == r_prescale - PRESCALE_WIDTH'(1));

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .edge_cnt   (r_edge_cnt),
    .Prescale   (r_prescale),
    .sampled_bit(w_sampled)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_edge_cnt_nxt   = r_edge_cnt;
    w_prescale_nxt   = r_prescale;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_p_data_nxt     = r_p_data;
    w_data_valid_nxt = 1'b0;
    w_stop_error_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en_nxt       = r_par_en;
    w_par_typ_nxt      = r_par_typ;
    w_par_err_nxt      = r_par_err;
    w_parity_error_nxt = 1'b0;
`endif
    if (r_state != IDLE) begin
      w_edge_cnt_nxt = w_bit_end ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);
    end
    unique case (r_state)
      IDLE: if (!RX_IN) w_state_nxt = START;
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = w_sampled ? IDLE : DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {w_sampled, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_cnt == BitCntW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = r_par_en ? PARITY : STOP;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BitCntW'(1);
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
`ifdef UART_RX_PARITY_EN
          w_par_err_nxt = ((^r_shift) ^ r_par_typ) != w_sampled;
`endif
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (w_sampled && !w_par_err) begin
            w_p_data_nxt     = r_shift;
            w_data_valid_nxt = 1'b1;
          end
          w_stop_error_nxt = !w_sampled;
`ifdef UART_RX_PARITY_EN
          w_parity_error_nxt = r_par_err;
`endif
          // A low line on the last stop edge is already the next start bit.
          w_state_nxt = RX_IN ? IDLE : START;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == START && r_state != START) begin
      w_prescale_nxt = w_prescale_in;
`ifdef UART_RX_PARITY_EN
      w_par_en_nxt  = PAR_EN;
      w_par_typ_nxt = PAR_TYP;
      w_par_err_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_edge_cnt   <= '0;
      r_prescale   <= PRESCALE_WIDTH'(PRESCALE_8);
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_stop_error <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_edge_cnt   <= w_edge_cnt_nxt;
      r_prescale   <= w_prescale_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_p_data     <= w_p_data_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_stop_error <= w_stop_error_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_par_err      <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      r_par_en       <= w_par_en_nxt;
      r_par_typ      <= w_par_typ_nxt;
      r_par_err      <= w_par_err_nxt;
      r_parity_error <= w_parity_error_nxt;
    end
  end
  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

  assign P_DATA     = r_p_data;
  assign data_valid = r_data_valid;
  assign stop_error = r_stop_error;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against a frame-level model with per-cycle output checks.
module tb_uart_rx_ctrl;

  localparam int PW = 6;

`ifdef UART_RX_PARITY_EN
  localparam bit ParOn = 1'b1;
`else
  localparam bit ParOn = 1'b0;
`endif

  logic          CLK, RST, RX_IN, PAR_EN, PAR_TYP;
  logic [PW-1:0] Prescale;
  logic [7:0]    P_DATA;
  logic          data_valid, parity_error, stop_error;

  uart_rx_ctrl #(
    .PRESCALE_WIDTH(PW),
    .DATA_WIDTH    (8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .parity_error(parity_error),
    .stop_error  (stop_error)
  );

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] pdata;
  } ev_t;

  ev_t        evq[$];
  ev_t        cur_ev;
  logic [7:0] dv_log[$];
  logic [7:0] model_pdata = 8'h00;
  bit         e_dv, e_pe, e_se;
  int         total = 0, bad = 0, cyc = 0;
  int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: outputs are idle except where a queued frame outcome lands.
  always @(negedge CLK) begin
    e_dv = 1'b0;
    e_pe = 1'b0;
    e_se = 1'b0;
    if (!RST) begin
      model_pdata = 8'h00;
    end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
      cur_ev = evq.pop_front();
      e_dv = cur_ev.dv;
      e_pe = cur_ev.pe;
      e_se = cur_ev.se;
      if (cur_ev.dv) model_pdata = cur_ev.pdata;
    end
    check("cycle", 32'({data_valid, parity_error, stop_error, P_DATA}),
          32'({e_dv, e_pe, e_se, model_pdata}));
    if (data_valid === 1'b1) begin
      dv_cnt++;
      dv_log.push_back(P_DATA);
    end
    if (parity_error === 1'b1) pe_cnt++;
    if (stop_error === 1'b1) se_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr_counts();
    dv_cnt = 0;
    pe_cnt = 0;
    se_cnt = 0;
    dv_log.delete();
  endtask

  // Called on a negedge; queues the frame outcome, then drives the line bit by bit.
  task automatic send_frame(input logic [7:0] d, input logic [PW-1:0] pres, input bit pen,
                            input bit ptyp, input bit pbit, input bit sbit, input bit scramble);
    int  p, nb;
    bit  pen_eff, stop_seen, par_ok;
    bit  line[$];
    ev_t ev;
    p = (pres == 6'd8 || pres == 6'd16 || pres == 6'd32) ? int'(pres) : 8;
    pen_eff = pen & ParOn;
    line.push_back(1'b0);
    for (int i = 0; i < 8; i++) line.push_back(d[i]);
    if (pen) line.push_back(pbit);
    line.push_back(sbit);
    nb = 10 + (pen_eff ? 1 : 0);
    stop_seen = line[nb-1];
    par_ok = !pen_eff || (pbit == ((^d) ^ ptyp));
    ev.cyc   = cyc + 1 + nb * p;
    ev.dv    = stop_seen && par_ok;
    ev.pe    = !par_ok;
    ev.se    = !stop_seen;
    ev.pdata = d;
    evq.push_back(ev);
    Prescale = pres;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    for (int b = 0; b < line.size(); b++) begin
      RX_IN = line[b];
      repeat (p) @(negedge CLK);
      if (scramble && b == 0) begin
        Prescale = (pres == 6'd8) ? 6'd16 : 6'd8;
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
      end
    end
    RX_IN = 1'b1;
  endtask

  logic [7:0] abort_byte;

  initial begin
    RST = 1'b0;
    RX_IN = 1'b1;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    #3;
    check("rst_pdata", 32'(P_DATA), 32'h0);
    check("rst_flags", 32'({data_valid, parity_error, stop_error}), 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(4);

    // Clean 8x frame, no parity
    clr_counts();
    send_frame(8'hCE, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    check("t032_dv_cnt", dv_cnt, 1);
    check("t032_err_cnt", pe_cnt + se_cnt, 0);
    check("t032_pdata", 32'(P_DATA), 32'hCE);

    // 16x frame with wrong even parity bit
    clr_counts();
    send_frame(8'hD1, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(12);
    check("t033_dv_cnt", dv_cnt, ParOn ? 0 : 1);
    check("t033_pe_cnt", pe_cnt, ParOn ? 1 : 0);
    check("t033_se_cnt", se_cnt, 0);
    check("t033_pdata", 32'(P_DATA), ParOn ? 32'hCE : 32'hD1);

    // Start glitch of 3 cycles
    clr_counts();
    Prescale = 6'd8;
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(30);
    check("t034_pulses", dv_cnt + pe_cnt + se_cnt, 0);
    check("t034_pdata", 32'(P_DATA), ParOn ? 32'hCE : 32'hD1);

    // Stop bit low
    clr_counts();
    send_frame(8'hCE, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(12);
    check("t035_se_cnt", se_cnt, 1);
    check("t035_dv_cnt", dv_cnt, 0);
    check("t035_pdata", 32'(P_DATA), ParOn ? 32'hCE : 32'hD1);

    // Back-to-back 32x frames
    clr_counts();
    send_frame(8'hCE, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hD1, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    check("t036_dv_cnt", dv_cnt, 2);
    check("t036_first", 32'((dv_log.size() > 0) ? dv_log[0] : 8'h00), 32'hCE);
    check("t036_second", 32'((dv_log.size() > 1) ? dv_log[1] : 8'h00), 32'hD1);

    // Config inputs change after the start edge
    clr_counts();
    send_frame(8'h3C, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(12);
    check("cfg_hold_dv_cnt", dv_cnt, 1);
    check("cfg_hold_pdata", 32'(P_DATA), 32'h3C);

    // Illegal ratio 12 behaves as 8
    clr_counts();
    send_frame(8'hA5, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    check("illegal_pre_dv_cnt", dv_cnt, 1);
    check("illegal_pre_pdata", 32'(P_DATA), 32'hA5);

    // Correct odd parity
    clr_counts();
    send_frame(8'h5A, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(12);
    check("odd_par_dv_cnt", dv_cnt, 1);
    check("odd_par_pe_cnt", pe_cnt, 0);
    check("odd_par_pdata", 32'(P_DATA), 32'h5A);

    // Reset in the middle of data bit 4, then a fresh frame
    clr_counts();
    abort_byte = 8'hCE;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    idle(8);
    for (int i = 0; i < 4; i++) begin
      RX_IN = abort_byte[i];
      idle(8);
    end
    RX_IN = abort_byte[4];
    idle(3);
    #2;
    RST = 1'b0;
    #1;
    check("t037_rst_pdata", 32'(P_DATA), 32'h0);
    check("t037_rst_flags", 32'({data_valid, parity_error, stop_error}), 32'h0);
    @(negedge CLK);
    RX_IN = 1'b1;
    idle(3);
    RST = 1'b1;
    idle(4);
    send_frame(8'hD1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    check("t037_dv_cnt", dv_cnt, 1);
    check("t037_err_cnt", pe_cnt + se_cnt, 0);
    check("t037_pdata", 32'(P_DATA), 32'hD1);

    check("pending_events", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
